// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin arbiter sharing one combinational ALU between
// N_REQ requesters. Two-stage pipeline: issue register (drives alu_*) and
// result register (drives resp_*) with a valid/ready handshake toward writeback.
module alu_issue_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned LOG_N = $clog2(N_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              req_valid_by_req,
  input  logic [N_REQ-1:0][3:0]         req_op_by_req,
  input  logic [N_REQ-1:0][63:0]        req_A_by_req,
  input  logic [N_REQ-1:0][63:0]        req_B_by_req,
  input  logic [N_REQ-1:0][TAG_W-1:0]   req_tag_by_req,
  output logic [N_REQ-1:0]              req_ready_by_req,
  output logic [3:0]                    alu_op,
  output logic [63:0]                   alu_A,
  output logic [63:0]                   alu_B,
  input  logic [63:0]                   alu_out,
  output logic                          resp_valid,
  output logic [63:0]                   resp_out,
  output logic [TAG_W-1:0]              resp_tag,
  output logic [LOG_N-1:0]              resp_req,
  input  logic                          resp_ready
);

  // One spare bit so rr_ptr + offset never overflows before the modulo fold.
  localparam int unsigned IDX_W = LOG_N + 1;

  logic                 issue_valid;
  logic [TAG_W-1:0]     issue_tag;
  logic [LOG_N-1:0]     issue_req;
  logic [LOG_N-1:0]     rr_ptr;

  logic                 s2_free;
  logic                 s1_adv;
  logic                 s1_free;
  logic                 accept;

  logic [IDX_W-1:0]     scan_idx;
  logic                 grant_any;
  logic [LOG_N-1:0]     grant_idx;
  logic [N_REQ-1:0]     grant_vec;
  logic [LOG_N-1:0]     rr_next;

  assign s2_free = ~resp_valid | resp_ready;
  assign s1_adv  = issue_valid & s2_free;
  assign s1_free = ~issue_valid | s1_adv;
  assign accept  = grant_any & s1_free & ~RST;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = IDX_W'(rr_ptr) + IDX_W'(k);
      if (scan_idx >= IDX_W'(N_REQ)) begin
        scan_idx = scan_idx - IDX_W'(N_REQ);
      end
      if (!grant_any && req_valid_by_req[LOG_N'(scan_idx)]) begin
        grant_any = 1'b1;
        grant_idx = LOG_N'(scan_idx);
      end
    end
    if (accept) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready_by_req = grant_vec;
  assign rr_next = (grant_idx == LOG_N'(N_REQ - 1)) ? '0 : grant_idx + LOG_N'(1);

  // Issue stage: load the winner, otherwise drop valid once the op moves on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issue_valid <= 1'b0;
      alu_op      <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      issue_tag   <= '0;
      issue_req   <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      issue_valid <= 1'b1;
      alu_op      <= req_op_by_req[grant_idx];
      alu_A       <= req_A_by_req[grant_idx];
      alu_B       <= req_B_by_req[grant_idx];
      issue_tag   <= req_tag_by_req[grant_idx];
      issue_req   <= grant_idx;
      rr_ptr      <= rr_next;
    end else if (s1_adv) begin
      issue_valid <= 1'b0;
    end
  end

  // Result stage: capture ALU output on advance, clear valid when drained.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_tag   <= '0;
      resp_req   <= '0;
    end else if (s1_adv) begin
      resp_valid <= 1'b1;
      resp_out   <= alu_out;
      resp_tag   <= issue_tag;
      resp_req   <= issue_req;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
